incoming_ack_window_update: RTL

Pipelined stage directly upstream of user_defined_incoming. It accepts incoming ACK packets, reads the flow's window state (wnd_start, acked_wnd) from the flow-context memory, and applies the cumulative and selective ACK. It writes the updated window back to memory and presents old_wnd_start, wnd_start, new_c_acks_cnt, valid_selective_ack and acked_wnd to the user congestion-control logic. Throughput is one ACK per cycle, with back-to-back same-flow forwarding.

---
 rtl/incoming_ack_window_update_pkg.sv | 18 +
 rtl/incoming_ack_window_update_calc.sv | 52 +++++
 rtl/incoming_ack_window_update.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/incoming_ack_window_update_pkg.sv
// Shared constants for the incoming ACK window-update stage.
// Holds the default widths, the window size and the ACK packet type code.
// It also provides a helper that recognises ACK packets.
package incoming_ack_window_update_pkg;

  localparam int DEF_FLOW_ID_W  = 10;
  localparam int DEF_SEQ_W      = 32;
  localparam int DEF_WIN_SIZE   = 64;
  localparam int DEF_WIN_IND_W  = 7;   // $clog2(WIN_SIZE)+1, so that a count of WIN_SIZE fits
  localparam int DEF_TX_CNT_W   = 2;
  localparam int DEF_PKT_TYPE_W = 3;
  localparam int PKT_TYPE_ACK   = 1;

  function automatic logic is_ack_type(input logic [DEF_PKT_TYPE_W-1:0] pkt_type);
    return pkt_type == DEF_PKT_TYPE_W'(PKT_TYPE_ACK);
  endfunction

endpackage

// File: rtl/incoming_ack_window_update_calc.sv
// Purely combinational window update for a single ACK.
// Inputs : pkt_type, old_start/old_wnd (the flow state before the update),
//          cum (cumulative ack), sack (selectively acked sequence number).
// Outputs: new_start, new_c_acks_cnt, valid_selective_ack, new_wnd.
// All sequence arithmetic wraps modulo 2^SEQ_W.
module incoming_ack_window_update_calc
  import incoming_ack_window_update_pkg::*;
#(
  parameter int SEQ_W      = DEF_SEQ_W,
  parameter int WIN_SIZE   = DEF_WIN_SIZE,
  parameter int WIN_IND_W  = DEF_WIN_IND_W,
  parameter int PKT_TYPE_W = DEF_PKT_TYPE_W
) (
  input  logic [PKT_TYPE_W-1:0] pkt_type,
  input  logic [SEQ_W-1:0]      old_start,
  input  logic [WIN_SIZE-1:0]   old_wnd,
  input  logic [SEQ_W-1:0]      cum,
  input  logic [SEQ_W-1:0]      sack,
  output logic [SEQ_W-1:0]      new_start,
  output logic [WIN_IND_W-1:0]  new_c_acks_cnt,
  output logic                  valid_selective_ack,
  output logic [WIN_SIZE-1:0]   new_wnd
);

  localparam int IDX_W = $clog2(WIN_SIZE);

  logic                is_ack;
  logic                cum_ok;
  logic [SEQ_W-1:0]    d;
  logic [SEQ_W-1:0]    off;
  logic [WIN_SIZE-1:0] shifted;
  logic [WIN_SIZE-1:0] sack_bit;

  always_comb begin
    is_ack = (pkt_type == PKT_TYPE_W'(PKT_TYPE_ACK));
    // An ACK that sits behind the window wraps to a huge d and is ignored.
    d      = cum - old_start;
    cum_ok = is_ack && (d != '0) && (d <= SEQ_W'(WIN_SIZE));

    new_start      = cum_ok ? cum : old_start;
    new_c_acks_cnt = cum_ok ? d[WIN_IND_W-1:0] : '0;
    // A shift amount of WIN_SIZE shifts every bit out, which clears the bitmap.
    shifted        = cum_ok ? (old_wnd >> d) : old_wnd;

    // The SACK offset is taken relative to the post-cumulative window start.
    off                 = sack - new_start;
    valid_selective_ack = is_ack && (off < SEQ_W'(WIN_SIZE));
    sack_bit            = valid_selective_ack ? (WIN_SIZE'(1) << off[IDX_W-1:0]) : '0;
    new_wnd             = shifted | sack_bit;
  end

endmodule

// File: rtl/incoming_ack_window_update.sv
// Incoming ACK window-update stage, placed directly ahead of the user
// congestion-control logic.
// S0 accepts an ACK and issues the flow-context read. S1 applies the
// cumulative/selective ACK and writes the new state back. The output stage
// then presents the result.
// Ports: in_* handshake and ACK fields; ctx_rd_* is the context read port
//        (data arrives one cycle after ctx_rd_en); ctx_wr_* is the context
//        write port; out_* handshake, registered ACK fields and the window
//        results.
// Throughput is one ACK per cycle. When the accepted ACK targets the flow
// being written in that same cycle, the write data is forwarded because the
// memory is read-before-write.
module incoming_ack_window_update
  import incoming_ack_window_update_pkg::*;
#(
  parameter int FLOW_ID_W  = DEF_FLOW_ID_W,
  parameter int SEQ_W      = DEF_SEQ_W,
  parameter int WIN_SIZE   = DEF_WIN_SIZE,
  parameter int WIN_IND_W  = DEF_WIN_IND_W,
  parameter int TX_CNT_W   = DEF_TX_CNT_W,
  parameter int PKT_TYPE_W = DEF_PKT_TYPE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOW_ID_W-1:0]  in_flow_id,
  input  logic [PKT_TYPE_W-1:0] in_pkt_type,
  input  logic [SEQ_W-1:0]      in_cumulative_ack,
  input  logic [SEQ_W-1:0]      in_selective_ack,
  input  logic [TX_CNT_W-1:0]   in_sack_tx_id,
  output logic                  ctx_rd_en,
  output logic [FLOW_ID_W-1:0]  ctx_rd_flow,
  input  logic [SEQ_W-1:0]      ctx_rd_wnd_start,
  input  logic [WIN_SIZE-1:0]   ctx_rd_acked_wnd,
  output logic                  ctx_wr_en,
  output logic [FLOW_ID_W-1:0]  ctx_wr_flow,
  output logic [SEQ_W-1:0]      ctx_wr_wnd_start,
  output logic [WIN_SIZE-1:0]   ctx_wr_acked_wnd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOW_ID_W-1:0]  out_flow_id,
  output logic [PKT_TYPE_W-1:0] out_pkt_type,
  output logic [SEQ_W-1:0]      out_cumulative_ack,
  output logic [SEQ_W-1:0]      out_selective_ack,
  output logic [TX_CNT_W-1:0]   out_sack_tx_id,
  output logic [SEQ_W-1:0]      out_old_wnd_start,
  output logic [SEQ_W-1:0]      out_wnd_start,
  output logic [WIN_IND_W-1:0]  out_new_c_acks_cnt,
  output logic                  out_valid_selective_ack,
  output logic [WIN_SIZE-1:0]   out_acked_wnd
);

  logic                  fire;
  logic                  s1_adv;
  logic                  s1_valid_reg;
  logic                  s1_first_reg;   // high in the cycle the context read data is on ctx_rd_*
  logic [FLOW_ID_W-1:0]  s1_flow_reg;
  logic [PKT_TYPE_W-1:0] s1_type_reg;
  logic [SEQ_W-1:0]      s1_cum_reg;
  logic [SEQ_W-1:0]      s1_sack_reg;
  logic [TX_CNT_W-1:0]   s1_tx_reg;
  logic                  fwd_hit_reg;
  logic [SEQ_W-1:0]      fwd_start_reg;
  logic [WIN_SIZE-1:0]   fwd_wnd_reg;
  logic [SEQ_W-1:0]      hold_start_reg;
  logic [WIN_SIZE-1:0]   hold_wnd_reg;

  logic [SEQ_W-1:0]      ctx_start;
  logic [WIN_SIZE-1:0]   ctx_wnd;
  logic [SEQ_W-1:0]      calc_start;
  logic [WIN_IND_W-1:0]  calc_cnt;
  logic                  calc_vsack;
  logic [WIN_SIZE-1:0]   calc_wnd;

  assign s1_adv      = s1_valid_reg & (~out_valid | out_ready);
  assign in_ready    = ~s1_valid_reg | s1_adv;
  assign fire        = in_valid & in_ready;
  assign ctx_rd_en   = fire;
  assign ctx_rd_flow = in_flow_id;

  // The write-back happens on the S1 -> output transfer, whatever out_ready does afterwards.
  assign ctx_wr_en        = s1_adv;
  assign ctx_wr_flow      = s1_flow_reg;
  assign ctx_wr_wnd_start = calc_start;
  assign ctx_wr_acked_wnd = calc_wnd;

  // Read data is only present for one cycle. After that, the hold copy is used while S1 stalls.
  always_comb begin
    ctx_start = hold_start_reg;
    ctx_wnd   = hold_wnd_reg;
    if (s1_first_reg) begin
      if (fwd_hit_reg) begin
        ctx_start = fwd_start_reg;
        ctx_wnd   = fwd_wnd_reg;
      end else begin
        ctx_start = ctx_rd_wnd_start;
        ctx_wnd   = ctx_rd_acked_wnd;
      end
    end
  end

  incoming_ack_window_update_calc #(
    .SEQ_W      (SEQ_W),
    .WIN_SIZE   (WIN_SIZE),
    .WIN_IND_W  (WIN_IND_W),
    .PKT_TYPE_W (PKT_TYPE_W)
  ) u_calc (
    .pkt_type            (s1_type_reg),
    .old_start           (ctx_start),
    .old_wnd             (ctx_wnd),
    .cum                 (s1_cum_reg),
    .sack                (s1_sack_reg),
    .new_start           (calc_start),
    .new_c_acks_cnt      (calc_cnt),
    .valid_selective_ack (calc_vsack),
    .new_wnd             (calc_wnd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg            <= 1'b0;
      s1_first_reg            <= 1'b0;
      s1_flow_reg             <= '0;
      s1_type_reg             <= '0;
      s1_cum_reg              <= '0;
      s1_sack_reg             <= '0;
      s1_tx_reg               <= '0;
      fwd_hit_reg             <= 1'b0;
      fwd_start_reg           <= '0;
      fwd_wnd_reg             <= '0;
      hold_start_reg          <= '0;
      hold_wnd_reg            <= '0;
      out_valid               <= 1'b0;
      out_flow_id             <= '0;
      out_pkt_type            <= '0;
      out_cumulative_ack      <= '0;
      out_selective_ack       <= '0;
      out_sack_tx_id          <= '0;
      out_old_wnd_start       <= '0;
      out_wnd_start           <= '0;
      out_new_c_acks_cnt      <= '0;
      out_valid_selective_ack <= 1'b0;
      out_acked_wnd           <= '0;
    end else begin
      if (fire) begin
        s1_valid_reg  <= 1'b1;
        s1_first_reg  <= 1'b1;
        s1_flow_reg   <= in_flow_id;
        s1_type_reg   <= in_pkt_type;
        s1_cum_reg    <= in_cumulative_ack;
        s1_sack_reg   <= in_selective_ack;
        s1_tx_reg     <= in_sack_tx_id;
        // The memory returns the pre-write value, so the write made in this cycle is captured here.
        fwd_hit_reg   <= ctx_wr_en && (ctx_wr_flow == in_flow_id);
        fwd_start_reg <= ctx_wr_wnd_start;
        fwd_wnd_reg   <= ctx_wr_acked_wnd;
      end else begin
        s1_first_reg <= 1'b0;
        if (s1_adv) begin
          s1_valid_reg <= 1'b0;
        end
      end

      if (s1_first_reg) begin
        hold_start_reg <= ctx_start;
        hold_wnd_reg   <= ctx_wnd;
      end

      if (s1_adv) begin
        out_valid               <= 1'b1;
        out_flow_id             <= s1_flow_reg;
        out_pkt_type            <= s1_type_reg;
        out_cumulative_ack      <= s1_cum_reg;
        out_selective_ack       <= s1_sack_reg;
        out_sack_tx_id          <= s1_tx_reg;
        out_old_wnd_start       <= ctx_start;
        out_wnd_start           <= calc_start;
        out_new_c_acks_cnt      <= calc_cnt;
        out_valid_selective_ack <= calc_vsack;
        out_acked_wnd           <= calc_wnd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
